// File: rtl/usb_rx_crc16_check.sv
// ---------------------------------------------------------------------------
// usb_rx_crc16_check
// Receive-side CRC16 checker and payload stripper for USB DATA packets.
// Consumes the post-PID byte stream (payload plus two CRC bytes), forwards
// payload bytes only, and reports a per-packet result at end of packet.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_data/valid   : received byte (bit 0 first on the wire), no backpressure
//   in_sop          : qualifies in_valid, first byte after PID
//   in_eop          : single-cycle end-of-packet strobe
//   in_abort        : receiver fault, drop current packet
//   out_data/valid  : payload byte strobe (registered)
//   pkt_done        : single-cycle result strobe (registered)
//   pkt_crc_ok      : residual correct and no error flag set
//   pkt_len         : payload bytes emitted, saturates at MAX_LEN
//   pkt_short       : fewer than two bytes received
//   pkt_overflow    : payload exceeded MAX_LEN
//   pkt_aborted     : ended by in_abort or a restarting in_sop
// ---------------------------------------------------------------------------
module usb_rx_crc16_check #(
  parameter int unsigned MAX_LEN = 1024,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_abort,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             pkt_done,
  output logic             pkt_crc_ok,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_short,
  output logic             pkt_overflow,
  output logic             pkt_aborted
);

  localparam logic [15:0]      CRC_INIT     = 16'hFFFF;
  localparam logic [15:0]      CRC_POLY     = 16'h8005;
  localparam logic [15:0]      CRC_RESIDUAL = 16'h800D;
  localparam logic [LEN_W-1:0] LEN_MAX      = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL1  = 2'd1,
    S_FILL2  = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  // One byte of CRC16, eight unrolled steps, bit 0 first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = data[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       hold0_q, hold0_d;   // oldest held byte
  logic [7:0]       hold1_q, hold1_d;   // newest held byte
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       out_data_d;
  logic             out_valid_d;
  logic             pkt_done_d;
  logic             pkt_crc_ok_d;
  logic [LEN_W-1:0] pkt_len_d;
  logic             pkt_short_d;
  logic             pkt_overflow_d;
  logic             pkt_aborted_d;

  // Event decode. Abort dominates everything; a byte is accepted only
  // inside a packet or when it opens one.
  logic        busy;
  logic        accept;
  logic        restart;
  logic        abort_end;
  logic        eop_end;
  logic        pkt_end;
  logic        emit_req;
  logic        len_full;
  logic        emit;
  logic [15:0] crc_cur;

  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid & ~in_abort & (busy | in_sop);
  assign restart   = accept & in_sop & busy;
  assign abort_end = in_abort & busy;
  assign eop_end   = in_eop & ~in_abort & ~restart & (busy | accept);
  assign pkt_end   = abort_end | eop_end | restart;
  // The third byte pushes the oldest held byte out; a restart drops it.
  assign emit_req  = accept & ~restart & ((state_q == S_FILL2) | (state_q == S_STREAM));
  assign len_full  = (len_q == LEN_MAX);
  assign emit      = emit_req & ~len_full;
  assign crc_cur   = accept ? crc16_byte(in_sop ? CRC_INIT : crc_q, in_data) : crc_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = eop_end ? S_IDLE : S_FILL1;
        end
      end
      default: begin
        if (abort_end) begin
          state_d = S_IDLE;
        end else if (restart) begin
          state_d = S_FILL1;
        end else if (eop_end) begin
          state_d = S_IDLE;
        end else if (accept) begin
          case (state_q)
            S_FILL1: state_d = S_FILL2;
            default: state_d = S_STREAM;
          endcase
        end
      end
    endcase
  end

  // Datapath and result next values.
  always_comb begin
    logic [15:0]      final_crc;
    logic [LEN_W-1:0] len_fin;
    logic             ovf_fin;
    logic             short_fin;
    logic             aborted_fin;

    hold0_d        = hold0_q;
    hold1_d        = hold1_q;
    crc_d          = crc_q;
    len_d          = len_q;
    ovf_d          = ovf_q;
    out_data_d     = out_data;
    out_valid_d    = 1'b0;
    pkt_done_d     = 1'b0;
    pkt_crc_ok_d   = pkt_crc_ok;
    pkt_len_d      = pkt_len;
    pkt_short_d    = pkt_short;
    pkt_overflow_d = pkt_overflow;
    pkt_aborted_d  = pkt_aborted;

    // Two-byte holdback shift buffer.
    if (accept) begin
      hold1_d = in_data;
      hold0_d = hold1_q;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = hold0_q;
    end

    len_fin = emit ? (len_q + LEN_W'(1)) : len_q;
    ovf_fin = ovf_q | (emit_req & len_full);

    // A restart reports the old packet, so its residual excludes the new byte.
    final_crc   = restart ? crc_q : crc_cur;
    aborted_fin = abort_end | restart;
    if (abort_end | restart) begin
      short_fin = (state_q == S_FILL1);
    end else begin
      short_fin = (state_q == S_IDLE) | ((state_q == S_FILL1) & ~accept);
    end

    if (restart) begin
      crc_d = crc_cur;
      len_d = '0;
      ovf_d = 1'b0;
    end else if (pkt_end) begin
      crc_d = CRC_INIT;
      len_d = '0;
      ovf_d = 1'b0;
    end else begin
      crc_d = crc_cur;
      len_d = len_fin;
      ovf_d = ovf_fin;
    end

    if (pkt_end) begin
      pkt_done_d     = 1'b1;
      pkt_len_d      = len_fin;
      pkt_short_d    = short_fin;
      pkt_overflow_d = ovf_fin;
      pkt_aborted_d  = aborted_fin;
      pkt_crc_ok_d   = (final_crc == CRC_RESIDUAL) & ~short_fin & ~ovf_fin & ~aborted_fin;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q        <= CRC_INIT;
      hold0_q      <= 8'h00;
      hold1_q      <= 8'h00;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      out_data     <= 8'h00;
      out_valid    <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_crc_ok   <= 1'b0;
      pkt_len      <= '0;
      pkt_short    <= 1'b0;
      pkt_overflow <= 1'b0;
      pkt_aborted  <= 1'b0;
    end else begin
      crc_q        <= crc_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      out_data     <= out_data_d;
      out_valid    <= out_valid_d;
      pkt_done     <= pkt_done_d;
      pkt_crc_ok   <= pkt_crc_ok_d;
      pkt_len      <= pkt_len_d;
      pkt_short    <= pkt_short_d;
      pkt_overflow <= pkt_overflow_d;
      pkt_aborted  <= pkt_aborted_d;
    end
  end

endmodule
